int16_to_bf16_cvt: RTL
======================

Name: int16_to_bf16_cvt

Overview:
- Sequential converter from a signed two's-complement integer to BFloat16 fields {s, e, m}.
- It is the producer side of the adder datapath: its {s_o, e_o, m_o} outputs drive the adder's operand inputs directly.
- Rounding is round-toward-zero (truncation), matching the adder. Normalisation is iterative, one bit per cycle.
- Input and output each use a valid/ready handshake. One conversion is in flight at a time.

Parameters:
- W, 16, integer input width (two's complement). Constraint: M < W and BIAS + W - 1 < 2^E - 1.
- E, 8, exponent width.
- M, 7, stored mantissa width (hidden 1 excluded).
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- valid_i  in  1  input integer valid.
- ready_o  out  1  converter can accept an input.
- data_i  in  W  signed integer to convert.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- s_o  out  1  sign.
- e_o  out  E  biased exponent.
- m_o  out  M  mantissa.

Behaviour:
- Clocking and reset: one clock (clk); reset nreset is asynchronous, active-low.
- Reset values: state=IDLE, ready_o=1, valid_o=0, s_o=0, e_o=0, m_o=0.
  - Reset asserted mid-conversion discards the operation; no partial result is ever presented.
- Internal registers: mag[W-1:0] (unsigned), exp[E-1:0], sgn.
- IDLE: ready_o=1, valid_o=0. On valid_i & ready_o (accept edge T0):
  - sgn = data_i[W-1].
  - mag = |data_i|, computed modulo 2^W. The most negative value gives mag = 2^(W-1) and needs no overflow handling.
  - If mag==0: go to DONE with s=0, e=0, m=0.
  - Otherwise: exp = BIAS + W - 1, go to NORM.
- NORM: ready_o=0, valid_o=0. Each cycle:
  - If mag[W-1]==1: latch s_o=sgn, e_o=exp, m_o=mag[W-2 -: M], go to DONE. Lower bits are truncated (RTZ).
  - Else: mag <<= 1 and exp -= 1.
- DONE: valid_o=1, ready_o=0.
  - s_o/e_o/m_o are held stable while valid_o & ~ready_i.
  - On ready_i: go to IDLE, clear valid_o.
  - Output registers keep their last value in IDLE; only valid_o qualifies them.
- Latency: for a nonzero input with k leading zeros in mag, valid_o rises after edge T0+k+1 (range 1..W edges). For a zero input, valid_o rises after edge T0.
- Throughput: a new input is accepted no earlier than the edge after the DONE handshake. There is no bypass from DONE to accept in the same cycle.
- valid_i while ready_o=0 is ignored. The upstream must hold data_i until accepted.
- exp never underflows: the minimum is BIAS for mag==1, so no subnormal, inf or NaN is ever produced.

Decomposition:
- Shared package bf16_pkg holds:
  - constants BF16_E=8, BF16_M=7, BF16_BIAS=127;
  - typedef bf16_t {s, e[E-1:0], m[M-1:0]}, reused by the adder and its benches;
  - the FSM state enum cvt_state_t {IDLE, NORM, DONE}.
- No sub-module: the iterative shift replaces the need for an LZC.

Test Plan:
- data_i=0x0001 -> s=0, e=127 (0x7F), m=0x00; valid_o after T0+16 edges.
- data_i=0x8000 (-32768) -> s=1, e=142 (0x8E), m=0x00; valid_o after T0+1.
- data_i=0x7FFF -> s=0, e=141 (0x8D), m=0x7F (truncated, not rounded up to e=142); valid_o after T0+2.
- data_i=0xFFFD (-3) -> s=1, e=128, m=0x40; data_i=0 -> s=0, e=0, m=0 with valid_o after T0.
- Backpressure: ready_i low for 5 cycles in DONE -> outputs stable, ready_o=0; a valid_i pulse with new data is ignored and the old result is delivered intact.
- Reset mid-NORM (data_i=0x0004, nreset low 2 cycles after accept) -> immediately valid_o=0, ready_o=1; the next conversion is correct.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared BFloat16 definitions for the int-to-bf16 converter and the adder datapath.
// Field widths, bias, the packed result type and the converter FSM states.
package bf16_pkg;

  localparam int BF16_E    = 8;
  localparam int BF16_M    = 7;
  localparam int BF16_BIAS = 127;

  typedef struct packed {
    logic              s;
    logic [BF16_E-1:0] e;
    logic [BF16_M-1:0] m;
  } bf16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } cvt_state_t;

endpackage

// File: rtl/int16_to_bf16_cvt.sv
// Iterative signed-integer to BFloat16 converter, round-toward-zero.
// Normalises one bit per cycle by left-shifting the magnitude until its MSB is set.
module int16_to_bf16_cvt
  import bf16_pkg::*;
#(
  parameter int W    = 16,
  parameter int E    = BF16_E,
  parameter int M    = BF16_M,
  parameter int BIAS = BF16_BIAS
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o
);

  // Exponent of an input whose magnitude already has bit W-1 set.
  localparam logic [E-1:0] EXP_TOP = E'(BIAS + W - 1);

  cvt_state_t   state;
  logic [W-1:0] mag;
  logic [E-1:0] expo;
  logic         sgn;
  logic [W-1:0] abs_in;

  // Two's-complement negate wraps the most negative value onto 2^(W-1), which is its true magnitude.
  assign abs_in = data_i[W-1] ? (~data_i + W'(1)) : data_i;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      s_o     <= 1'b0;
      e_o     <= '0;
      m_o     <= '0;
      mag     <= '0;
      expo    <= '0;
      sgn     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            sgn     <= data_i[W-1];
            mag     <= abs_in;
            ready_o <= 1'b0;
            if (abs_in == '0) begin
              s_o     <= 1'b0;
              e_o     <= '0;
              m_o     <= '0;
              valid_o <= 1'b1;
              state   <= DONE;
            end else begin
              expo  <= EXP_TOP;
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mag[W-1]) begin
            s_o     <= sgn;
            e_o     <= expo;
            m_o     <= mag[W-2 -: M];
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            mag  <= mag << 1;
            expo <= expo - E'(1);
          end
        end

        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
